// File: rtl/accum_drain_pkg.sv
// accum_drain_pkg: shared widths, the sizing helper and the drain FSM state type.
// Latency: none, declarations only.
// Backpressure: not applicable.
package accum_drain_pkg;

    // Bits needed to index n items (ceil(log2(n))), never less than 1.
    function automatic int bw(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int RES_W = 24;          // accumulator result width per lane
    localparam int BATCH = 2;           // lanes per buffer entry
    localparam int SH_W  = bw(RES_W);   // shift-amount width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_fsm_t;

endpackage

// File: rtl/accum_drain_if.sv
// accum_drain_if: buffer read port plus the quantized output stream.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls out_valid/out_data.
// master = drain block (drives rd_addr, out_data, out_valid);
// slave  = buffer/consumer side (drives rd_data, out_ready).
interface accum_drain_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]                                         rd_addr;
    logic [accum_drain_pkg::BATCH*accum_drain_pkg::RES_W-1:0]  rd_data;
    logic [accum_drain_pkg::BATCH*DATA_W-1:0]                  out_data;
    logic                                                      out_valid;
    logic                                                      out_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/accum_drain_res_quant.sv
// res_quant: one lane of round-half-up, arithmetic right shift and signed saturation.
// Latency: 1 cycle (output registered, free-running).
// Backpressure: none; the caller only pushes results it has credit for.
// Ports: clk, rst, shift (right-shift amount), in_dat (RES_W signed), out_dat (DATA_W signed).
// ACCUM_DRAIN_RELU_EN: when defined, negative inputs are zeroed before rounding.
module res_quant
    import accum_drain_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SH_W-1:0]   shift,
    input  logic [RES_W-1:0]  in_dat,
    output logic [DATA_W-1:0] out_dat
);
    localparam logic signed [RES_W:0] MAX_V = (RES_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [RES_W:0] MIN_V = ~MAX_V;

    logic signed [RES_W:0] x_ext;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] sum;
    logic signed [RES_W:0] t;
    logic [DATA_W-1:0]     sat;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        x_ext = {in_dat[RES_W-1], in_dat};
`ifdef ACCUM_DRAIN_RELU_EN
        if (in_dat[RES_W-1]) x_ext = '0;
`endif
        rnd = '0;
        if (shift != '0) rnd = (RES_W+1)'(1) << (shift - 1'b1);
        sum = x_ext + rnd;
        t   = sum >>> shift;
        if (t > MAX_V)      sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (t < MIN_V) sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                sat = t[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) out_dat <= '0;
        else     out_dat <= sat;
    end
endmodule

// File: rtl/accum_drain.sv
// accum_drain: sweeps the accumulation buffer read port and streams quantized lanes out.
// Latency: first beat out_valid RD_LAT+2 cycles after the start cycle, then 1 beat/cycle.
// Backpressure: credit-gated reads into an RD_LAT+2 deep FIFO; out_data holds while stalled.
// Ports: start/len/base_addr/shift (sampled on accepted start), busy, done,
//        bus (master): rd_addr -> buffer, rd_data <- buffer, out_data/out_valid/out_ready stream.
// ACCUM_DRAIN_RELU_EN: optional ReLU inside res_quant, latency unchanged.
module accum_drain
    import accum_drain_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bw(DEPTH):0]   len,
    input  logic [bw(DEPTH)-1:0] base_addr,
    input  logic [SH_W-1:0]      shift,
    output logic                 busy,
    output logic                 done,
    accum_drain_if.master        bus
);
    localparam int ADDR_W     = bw(DEPTH);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = bw(FIFO_DEPTH + 1);
    localparam int PTR_W      = bw(FIFO_DEPTH);

    drain_fsm_t              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W:0]         remain_q;
    logic [SH_W-1:0]         shift_q;
    logic                    issue, has_credit, push, pop;
    logic [RD_LAT-1:0]       pipe_vld;
    logic                    q_vld;
    logic [BATCH*DATA_W-1:0] q_dat;
    logic [BATCH*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        cnt_q, inflight_q;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots already spoken for: FIFO entries plus reads still in the pipe.
    // A pop this cycle frees a slot immediately.
    assign has_credit = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(inflight_q))
                      < ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop));

    // The first read goes out in the start cycle itself (everything is empty
    // in IDLE, so credit is guaranteed); later reads come from addr_q.
    assign bus.rd_addr = (state_q == IDLE && start) ? base_addr : addr_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = FLUSH;
                    end else begin
                        issue   = 1'b1;
                        state_d = (len == (ADDR_W+1)'(1)) ? FLUSH : DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (has_credit) begin
                    issue = 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                // Leave as the last beat handshakes so done follows it by one cycle.
                if (inflight_q == '0 &&
                    (cnt_q == '0 || (cnt_q == CNT_W'(1) && pop)))
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                shift_q  <= shift;
                remain_q <= len - 1'b1;
                addr_q   <= addr_inc(base_addr);
            end else if (issue) begin
                remain_q <= remain_q - 1'b1;
                addr_q   <= addr_inc(addr_q);
            end
        end
    end

    // Valid bits ride alongside the RAM latency; q_vld lines up with res_quant output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            q_vld    <= 1'b0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            q_vld <= pipe_vld[RD_LAT-1];
        end
    end

    for (genvar g = 0; g < BATCH; g++) begin : g_lane
        res_quant #(.DATA_W(DATA_W)) u_quant (
            .clk     (clk),
            .rst     (rst),
            .shift   (shift_q),
            .in_dat  (bus.rd_data[g*RES_W +: RES_W]),
            .out_dat (q_dat[g*DATA_W +: DATA_W])
        );
    end

    assign push          = q_vld;
    assign pop           = (cnt_q != '0) && bus.out_ready;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= q_dat;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            cnt_q      <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_accum_drain.sv
`timescale 1ns/1ps
module tb_accum_drain;
    import accum_drain_pkg::*;

    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = bw(DEPTH);
    localparam int OUT_W  = BATCH * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [SH_W-1:0]   shift = '0;
    logic              busy, done;

    accum_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    accum_drain #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .base_addr (base_addr),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data appears RD_LAT cycles after the address.
    logic [RES_W-1:0]  mem [DEPTH][BATCH];
    logic [ADDR_W-1:0] a_d [RD_LAT];
    always @(posedge clk) begin
        a_d[0] <= bus.rd_addr;
        for (int i = 1; i < RD_LAT; i++) a_d[i] <= a_d[i-1];
    end
    for (genvar l = 0; l < BATCH; l++) begin : g_rd
        assign bus.rd_data[l*RES_W +: RES_W] = mem[a_d[RD_LAT-1]][l];
    end

    // Ready modes: 0 always, 1 one-on/three-off, 2 never, 3 random.
    int   rdy_mode = 0;
    logic rnd_bit = 1'b0;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.out_ready = (rdy_mode == 0) || (rdy_mode == 1 && (cyc % 4) == 0) ||
                           (rdy_mode == 3 && rnd_bit);

    logic [OUT_W-1:0] exp_q[$];
    int   n_chk = 0, n_err = 0;
    int   hs_cnt = 0, last_hs_cyc = -1, first_vld_cyc = -1;
    bit   stall_prev = 1'b0;
    bit   occ_on = 1'b0;
    logic [OUT_W-1:0] prev_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: round half up, floor shift, clamp to DATA_W signed range.
    function automatic logic [DATA_W-1:0] quant_ref(input logic [RES_W-1:0] raw, input int sh);
        longint x, y, hi, lo;
        x = longint'($signed(raw));
`ifdef ACCUM_DRAIN_RELU_EN
        if (x < 0) x = 0;
`endif
        if (sh > 0) y = (x + (longint'(1) <<< (sh - 1))) >>> sh;
        else        y = x;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -hi - 1;
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y[DATA_W-1:0];
    endfunction

    task automatic push_model(input int b, input int n, input int sh);
        logic [OUT_W-1:0] e;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < BATCH; l++)
                e[l*DATA_W +: DATA_W] = quant_ref(mem[(b + k) % DEPTH][l], sh);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [OUT_W-1:0] pack_alt(input logic [DATA_W-1:0] ev,
                                                  input logic [DATA_W-1:0] od);
        logic [OUT_W-1:0] r;
        for (int l = 0; l < BATCH; l++) r[l*DATA_W +: DATA_W] = (l % 2 == 0) ? ev : od;
        return r;
    endfunction

    task automatic set_alt(input int a, input logic [RES_W-1:0] ev, input logic [RES_W-1:0] od);
        for (int l = 0; l < BATCH; l++) mem[a][l] = (l % 2 == 0) ? ev : od;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 64'(bus.out_valid), 64'd1);
                chk("stall_data_held", 64'(bus.out_data), 64'(prev_dat));
            end
            if (bus.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL extra_beat: got %0h expected no beat (cycle %0d)", bus.out_data, cyc);
                end else begin
                    chk("beat_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (occ_on) chk("fifo_occ_bound", 64'(dut.cnt_q <= RD_LAT + 2), 64'd1);
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_dat   = bus.out_data;
        end
    end

    task automatic run_drain(input int b, input int n, input int sh, input int mode,
                             input bit model, input bit inject);
        int t0, done_cyc;
        rdy_mode = mode;
        if (model) push_model(b, n, sh);
        hs_cnt = 0;
        first_vld_cyc = -1;
        done_cyc = -1;
        @(posedge clk); #1;
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(n);
        shift     = SH_W'(sh);
        start     = 1'b1;
        t0        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int budget = 0; budget < 3000; budget++) begin
            @(negedge clk);
            if (cyc == t0 + 1) chk("busy_after_start", 64'(busy), 64'd1);
            if (inject && cyc == t0 + 4) begin
                base_addr = ADDR_W'(5);
                len       = (ADDR_W+1)'(3);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_low_at_done", 64'(busy), 64'd0);
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done for base=%0d len=%0d", b, n);
        end else begin
            if (n == 0) begin
                chk("done_len0_timing", 64'(done_cyc), 64'(t0 + 2));
            end else begin
                chk("first_valid_latency", 64'(first_vld_cyc), 64'(t0 + RD_LAT + 2));
                chk("done_after_last_beat", 64'(done_cyc), 64'(last_hs_cyc + 1));
            end
            chk("beat_count", 64'(hs_cnt), 64'(n));
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        end
        @(negedge clk);
        chk("busy_idle_after", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int  budget;
        bit  seen_done;
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < BATCH; l++) mem[a][l] = RES_W'($urandom);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic pass-through drain.
        for (int a = 0; a < 4; a++) set_alt(a, RES_W'(5), RES_W'(-7));
        for (int k = 0; k < 4; k++) exp_q.push_back(pack_alt(DATA_W'(5), DATA_W'(-7)));
        run_drain(0, 4, 0, 0, 1'b0, 1'b0);

        // Rounding and saturation at shift 4.
        set_alt(10, RES_W'(24), RES_W'(-24));
        set_alt(11, 24'h7FFFFF, 24'h800000);
`ifdef ACCUM_DRAIN_RELU_EN
        exp_q.push_back(pack_alt(DATA_W'(2), DATA_W'(0)));
        exp_q.push_back(pack_alt(DATA_W'(32767), DATA_W'(0)));
`else
        exp_q.push_back(pack_alt(DATA_W'(2), DATA_W'(-1)));
        exp_q.push_back(pack_alt(DATA_W'(32767), DATA_W'(-32768)));
`endif
        run_drain(10, 2, 4, 0, 1'b0, 1'b0);

        // +/-100 at shift 2.
        set_alt(20, RES_W'(100), RES_W'(-100));
`ifdef ACCUM_DRAIN_RELU_EN
        exp_q.push_back(pack_alt(DATA_W'(25), DATA_W'(0)));
`else
        exp_q.push_back(pack_alt(DATA_W'(25), DATA_W'(-25)));
`endif
        run_drain(20, 1, 2, 0, 1'b0, 1'b0);

        // Backpressure 1-on/3-off.
        occ_on = 1'b1;
        run_drain(40, 16, int'($urandom_range(0, RES_W - 1)), 1, 1'b1, 1'b0);

        // Address wrap with random ready.
        run_drain(250, 10, int'($urandom_range(0, RES_W - 1)), 3, 1'b1, 1'b0);

        // Zero-length no-op.
        run_drain(0, 0, 0, 0, 1'b1, 1'b0);

        // Start while busy must be ignored.
        run_drain(60, 12, 5, 1, 1'b1, 1'b1);

        // Full-buffer sweep.
        run_drain(128, DEPTH, int'($urandom_range(0, RES_W - 1)), 3, 1'b1, 1'b0);

        // Reset after 3 beats of a len=8 drain.
        rdy_mode = 0;
        push_model(100, 8, 3);
        hs_cnt = 0;
        @(posedge clk); #1;
        base_addr = ADDR_W'(100);
        len       = (ADDR_W+1)'(8);
        shift     = SH_W'(3);
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        budget = 0;
        while (hs_cnt < 3 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (hs_cnt < 3) begin
            n_chk++;
            n_err++;
            $display("FAIL rst_test_timeout: got %0d beats expected 3", hs_cnt);
        end
        rst      = 1'b1;
        rdy_mode = 2;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        seen_done = done;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 64'(seen_done), 64'd0);
        chk("midrst_no_beats", 64'(bus.out_valid), 64'd0);

        // Clean drain after the abort.
        run_drain(200, 6, 1, 0, 1'b1, 1'b0);
        occ_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish before 5ms");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accum_drain.md
Name: accum_drain

Overview:
- Downstream stage of the PE accumulation buffer. After a ping-pong switch, it sweeps the buffer's store-result read port (rd_addr/rd_data) over a programmed range.
- Each BATCH lane is rounded, right-shifted and saturated from RES_W to DATA_W, then streamed out on a valid/ready interface toward the write-back path.
- Read issue is credit-throttled so RAM read latency never overruns the output under backpressure.

Parameters:
- DEPTH, 256, accumulation buffer entries.
- ADDR_W, bw(DEPTH), address width; derived, not overridden.
- RD_LAT, 2, cycles from rd_addr to valid rd_data; fixed RAM latency.
- DATA_W, 16, signed output width per lane.
- SH_W, bw(RES_W), shift-amount width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse, accepted only in IDLE
- len  in  ADDR_W+1  entries to drain, 1..DEPTH; sampled at start
- base_addr  in  ADDR_W  first address; sampled at start
- shift  in  SH_W  right-shift amount, 0..RES_W-1; sampled at start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last beat handshakes
- rd_addr  out  ADDR_W  to buffer store-result port
- rd_data  in  BATCH*RES_W  from buffer, RD_LAT after rd_addr
- out_data  out  BATCH*DATA_W  quantized lanes, lane i at [i*DATA_W +: DATA_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts when valid&ready

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, out_valid=0, rd_addr=0, out_data=0; FIFO and in-flight pipe cleared. Reset mid-drain aborts with no done pulse.
- FSM states:
  - IDLE: start moves to DRAIN and latches base_addr, len, shift. start while busy is ignored.
  - DRAIN: issues one read per cycle while credits>0; rd_addr increments and wraps DEPTH-1 -> 0. After len issues, moves to FLUSH.
  - FLUSH: waits until the in-flight pipe is empty, the FIFO is empty and the last beat has handshaked, then moves to DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle, then returns to IDLE.
- Read pipe: a valid bit travels RD_LAT stages alongside each issue. When it emerges, quantized rd_data is pushed into the output FIFO, whose depth is RD_LAT+2.
- Credits:
  - credits = FIFO depth - (FIFO occupancy + in-flight count); an issue requires credits>0.
  - A pop on the same cycle as an issue returns its credit that cycle.
  - The FIFO therefore never overflows; overflow is an assertion failure.
- Output is the FIFO head: out_valid = !empty; pop on valid&ready. out_data must hold stable while valid & !ready.
- Throughput: with out_ready held high, one beat per cycle. First beat is out_valid at start+RD_LAT+2.
- Quantize, per lane, signed:
  - shift=0: pass-through.
  - shift>0: t = x + (1<<(shift-1)) computed in RES_W+1 bits, then arithmetic >> shift.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Quantization is registered once, inside the RD_LAT+1 path to the FIFO.
- len=0 at start: treated as no-op; DONE pulse two cycles later, no reads and no beats.

Optional Feature:
- Macro ACCUM_DRAIN_RELU_EN.
  - Defined: negative lanes are forced to 0 before rounding, so out_data is never negative.
  - Undefined: signed saturation only, as above.
  - Latency identical either way.

Decomposition:
- GLOBAL_PARAM supplies bw, RES_W and BATCH. Add DRAIN_FSM_T, the state enum {IDLE, DRAIN, FLUSH, DONE}, to GLOBAL_PARAM.
- Sub-module res_quant holds the per-lane round/shift/saturate/ReLU logic, one registered stage. It is instantiated BATCH times in a generate loop.
- Output FIFO and credit counter stay inline.

Test Plan:
- Basic drain: base=0, len=4, shift=0, ready=1, lane values 5, -7 -> four beats in address order, values unchanged; done one cycle after the 4th handshake.
- Rounding and saturation, shift=4, DATA_W=16:
  - x=24 -> 2
  - x=-24 -> -1
  - x=0x7FFFFF -> 32767
  - x=-0x800000 -> -32768
- Backpressure: len=16, out_ready toggles 1-cycle-on/3-off -> no lost or duplicated beats, FIFO never exceeds RD_LAT+2, out_data stable while stalled.
- Wrap-around: base=250, len=10, DEPTH=256 -> rd_addr sequence 250..255, 0..3.
- Reset and control corners:
  - rst asserted after 3 beats of len=8 -> out_valid=0 next cycle, no done; a new start then drains cleanly from the new base.
  - start during busy -> ignored.
- With ACCUM_DRAIN_RELU_EN: x=-100 -> 0, x=100 with shift=2 -> 25.
